manchester_rx: RTL and testbench
================================

Name: manchester_rx

Overview:
Serial Manchester (IEEE 802.3 convention) frame decoder. It is the receive end of the single-wire link whose transmitter drives line_in.
- Oversamples line_in, locks onto the start-bit mid transition and recovers DATA_W data bits, MSB first.
- Presents each decoded word with a one-cycle valid pulse and flags code violations.
- Sits between the board pin and the lab's word-level consumer logic.

Parameters:
OVERSAMPLE, 8, clock cycles per Manchester bit; must be a multiple of 4 and at least 8.
DATA_W, 8, data bits per frame.

Ports:
clk  input  1  system clock, rising edge.
rst_n  input  1  asynchronous active-low reset.
line_in  input  1  raw serial line, asynchronous to clk; idle level low.
data_out  output  DATA_W  last decoded word; holds until the next good frame.
data_valid  output  1  one-cycle pulse when data_out is updated.
frame_err  output  1  one-cycle pulse on a code violation or an aborted frame.
busy  output  1  high from start detection until the return to IDLE.
parity_err  output  1  see Optional Feature.

Behaviour:
- Reset and clocking
  - One clock. Reset is asynchronous and active-low (rst_n).
  - Reset clears all outputs and the synchronizer to 0 and forces IDLE.
  - Reset mid-frame discards the partial word; no valid or error pulse is produced.
- Input synchronizer and encoding
  - line_in passes through a 2-flop synchronizer. All timing below is in clk cycles on the synchronized signal s, with t=0 at the first cycle s is high after being low.
  - Bit encoding: 1 = low then high; 0 = high then low. Bit value equals the second-half level.
  - Frame: start bit '1', then DATA_W bits MSB first, then the line returns low.
- State machine: IDLE, START_CHK, DATA, DONE, REARM.
  - IDLE: busy=0. A rising edge on s moves to START_CHK and clears the sample counter.
  - START_CHK: at t=OVERSAMPLE/4, if s=1 go to DATA. Otherwise go to IDLE silently (glitch reject).
  - DATA: for bit k = 0..DATA_W-1:
    - first-half sample at t = k*OVERSAMPLE + 3*OVERSAMPLE/4;
    - second-half sample at t = k*OVERSAMPLE + 5*OVERSAMPLE/4.
    - If the two samples are equal: pulse frame_err, go to REARM, leave data_out unchanged.
    - Otherwise shift the second sample into the shift register.
  - DONE: one cycle after the last second-half sample, load data_out, pulse data_valid, go to REARM.
  - REARM: busy stays 1. Return to IDLE after OVERSAMPLE consecutive cycles of s=0.
    - An edge during REARM is ignored; a new frame needs a clean idle.
- Counters: the sample counter wraps per bit (0..OVERSAMPLE-1). The bit counter is sized clog2(DATA_W+1) and saturates at DATA_W.
- Latency: data_valid rises 2 (sync) + DATA_W*OVERSAMPLE + OVERSAMPLE/4 + 1 cycles after the raw start edge, relative to the mid-bit edge of the start bit.
- data_valid and frame_err are never both high in the same cycle.

Optional Feature:
Macro: MANCH_PARITY_EN.
- Defined:
  - The frame carries one extra Manchester bit after the data: even parity over the data bits.
  - It is sampled exactly like a data bit.
  - On mismatch, data_out still loads, data_valid pulses, and parity_err pulses in the same cycle.
  - A code violation in the parity bit gives frame_err only.
- Undefined: no parity bit is expected and parity_err is tied to 0.

Decomposition:
- Package manchester_pkg: state encodings, the quarter/three-quarter/five-quarter offset constants derived from OVERSAMPLE, and the IDLE line level constant.
- Sub-module sync_2ff: the 2-flop synchronizer with async active-low reset to 0. It is reusable across the lab designs.

Test Plan:
- OVERSAMPLE=8, DATA_W=8, send 0xA5 -> data_out=0xA5, one data_valid pulse, frame_err=0, busy falls 8 cycles after the line returns low.
- Send 0x3C with bit 3 held high for the full bit -> frame_err pulses once, no data_valid, data_out keeps its previous value.
- 2-cycle high glitch on an idle line -> no busy beyond START_CHK, no pulses, back in IDLE.
- Back-to-back 0xFF then 0x00 with exactly 8 idle-low cycles between -> two data_valid pulses, words correct in order.
- Assert rst_n low mid-word (after bit 4) -> all outputs 0 immediately; the next full frame 0x81 decodes correctly.
- MANCH_PARITY_EN defined: send 0x07 with parity bit 0 -> data_out=0x07, data_valid and parity_err in the same cycle. With parity bit 1 -> parity_err=0.

Source files
------------

// File: rtl/manchester_pkg.sv
// Shared types and timing constants for the Manchester receiver.
// Sample offsets are derived from the per-bit oversampling ratio.
package manchester_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START_CHK,
    S_DATA,
    S_DONE,
    S_REARM
  } state_t;

  localparam int   OS_DEF    = 8;
  localparam logic LINE_IDLE = 1'b0;

  function automatic int qtr_off(input int os);
    return os / 4;
  endfunction

  function automatic int three_qtr_off(input int os);
    return (3 * os) / 4;
  endfunction

  function automatic int five_qtr_off(input int os);
    return (5 * os) / 4;
  endfunction

  localparam int QTR_DEF   = qtr_off(OS_DEF);
  localparam int TQTR_DEF  = three_qtr_off(OS_DEF);
  localparam int FQTR_DEF  = five_qtr_off(OS_DEF);

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input.
// Async active-low reset drives both stages to 0.
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/manchester_rx.sv
// Oversampling Manchester frame decoder, start bit '1', data MSB first.
// Define MANCH_PARITY_EN to expect a trailing even-parity bit.
module manchester_rx
  import manchester_pkg::*;
#(
  parameter int OVERSAMPLE = OS_DEF,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              line_in,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              frame_err,
  output logic              busy,
  output logic              parity_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] PH_Q    = CW'(qtr_off(OVERSAMPLE));
  localparam logic [CW-1:0] PH_3Q   = CW'(three_qtr_off(OVERSAMPLE));
  localparam logic [CW-1:0] PH_5Q   =
    CW'(five_qtr_off(OVERSAMPLE) - OVERSAMPLE);
  localparam logic [CW-1:0] PH_LAST = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_MAX = BW'(DATA_W);

`ifdef MANCH_PARITY_EN
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W);
`else
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
`endif

  logic              w_s;
  logic              w_rise;
  logic [CW-1:0]     w_cnt_nxt;
  logic [DATA_W-1:0] w_word;
  logic              w_par_bad;

  state_t            r_state;
  logic              r_s_d;
  logic [CW-1:0]     r_cnt;
  logic [BW-1:0]     r_bit;
  logic              r_first;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_ferr;
  logic              r_perr;
  logic              r_busy;

  sync_2ff u_sync (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_d     (line_in),
    .o_q     (w_s)
  );

  assign w_rise    = (w_s != LINE_IDLE) && (r_s_d == LINE_IDLE);
  assign w_cnt_nxt = (r_cnt == PH_LAST) ? '0 : r_cnt + CW'(1);

`ifdef MANCH_PARITY_EN
  assign w_word    = r_shift;
  assign w_par_bad = (^r_shift) != w_s;
`else
  assign w_word    = {r_shift[DATA_W-2:0], w_s};
  assign w_par_bad = 1'b0;
`endif

  // r_cnt tracks the phase within the current bit period
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_s_d   <= 1'b0;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_first <= 1'b0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_s_d   <= w_s;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      r_perr  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_rise) begin
            r_state <= S_START_CHK;
            r_busy  <= 1'b1;
            r_cnt   <= CW'(1);
            r_bit   <= '0;
          end
        end
        S_START_CHK: begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt == PH_Q) begin
            if (w_s != LINE_IDLE) begin
              r_state <= S_DATA;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_DATA: begin
          r_cnt <= w_cnt_nxt;
          if (r_cnt == PH_3Q) r_first <= w_s;
          if (r_cnt == PH_5Q) begin
            if (w_s == r_first) begin
              r_ferr  <= 1'b1;
              r_state <= S_REARM;
              r_cnt   <= '0;
            end else begin
              if (r_bit != BIT_MAX) r_bit <= r_bit + BW'(1);
              if (r_bit < BIT_MAX)
                r_shift <= {r_shift[DATA_W-2:0], w_s};
              if (r_bit == BIT_LAST) begin
                r_state <= S_DONE;
                r_data  <= w_word;
                r_valid <= 1'b1;
                r_perr  <= w_par_bad;
              end
            end
          end
        end
        S_DONE: begin
          r_state <= S_REARM;
          r_cnt   <= '0;
        end
        S_REARM: begin
          if (w_s != LINE_IDLE) begin
            r_cnt <= '0;
          end else if (r_cnt == PH_LAST) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign data_out   = r_data;
  assign data_valid = r_valid;
  assign frame_err  = r_ferr;
  assign busy       = r_busy;
  assign parity_err = r_perr;

endmodule

// File: tb/tb_manchester_rx.sv
// Directed bench for manchester_rx (OVERSAMPLE=8, DATA_W=8).
// Parity cases are compiled in when MANCH_PARITY_EN is defined.
module tb_manchester_rx;

  localparam int OS = 8;
  localparam int DW = 8;
  localparam int Q  = OS / 4;
`ifdef MANCH_PARITY_EN
  localparam int NB = DW + 1;
`else
  localparam int NB = DW;
`endif
  localparam int LAT  = 2 + NB * OS + Q + 1;
  localparam int IDLE_DLY = 2 + OS;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          line_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          data_valid;
  logic          frame_err;
  logic          busy;
  logic          parity_err;

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_perr_v = 0;
  int n_both = 0, n_busy = 0, cyc = 0;
  int t_valid = 0, t_edge = 0;
  logic [DW-1:0] words[$];
`ifdef MANCH_PARITY_EN
  int par_force = -1;
`endif

  manchester_rx #(.OVERSAMPLE(OS), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .line_in    (line_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .frame_err  (frame_err),
    .busy       (busy),
    .parity_err (parity_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (data_valid) begin
        n_valid++;
        t_valid = cyc;
        words.push_back(data_out);
        if (parity_err) n_perr_v++;
      end
      if (frame_err) n_ferr++;
      if (parity_err) n_perr++;
      if (data_valid && frame_err) n_both++;
      if (busy) n_busy++;
    end
  end

  initial begin
    #200us;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic half(input logic lvl);
    for (int i = 0; i < OS / 2; i++) begin
      line_in = lvl;
      tick();
    end
  endtask

  task automatic send_bit(input logic b);
    half(~b);
    half(b);
  endtask

  task automatic send_frame(input logic [DW-1:0] w, input int viol);
    half(1'b0);
    t_edge = cyc + 1;
    half(1'b1);
    for (int i = DW - 1; i >= 0; i--) begin
      if (i == viol) begin
        half(1'b1);
        half(1'b1);
      end else begin
        send_bit(w[i]);
      end
    end
`ifdef MANCH_PARITY_EN
    if (par_force < 0) send_bit(^w);
    else send_bit(par_force != 0);
`endif
    line_in = 1'b0;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int b0;
    logic [7:0] w5a;
    w5a = 8'h5A;

    repeat (3) tick();
    chk("rst data_out", data_out, 0);
    chk("rst data_valid", data_valid, 0);
    chk("rst frame_err", frame_err, 0);
    chk("rst busy", busy, 0);
    chk("rst parity_err", parity_err, 0);
    rst_n = 1'b1;
    repeat (4) tick();

    send_frame(8'hA5, -1);
    wait_idle(n);
    chk("a5 busy fall", n, IDLE_DLY);
    chk("a5 valid count", n_valid, 1);
    chk("a5 data_out", data_out, 8'hA5);
    chk("a5 frame_err", n_ferr, 0);
    chk("a5 latency", t_valid - t_edge, LAT);
    repeat (4) tick();

    send_frame(8'h3C, 3);
    wait_idle(n);
    chk("viol frame_err", n_ferr, 1);
    chk("viol no valid", n_valid, 1);
    chk("viol data_out", data_out, 8'hA5);
    chk("viol busy", busy, 0);
    repeat (4) tick();

    b0 = n_busy;
    line_in = 1'b1;
    tick();
    tick();
    line_in = 1'b0;
    repeat (12) tick();
    chk("glitch busy cycles", n_busy - b0, 2);
    chk("glitch busy", busy, 0);
    chk("glitch pulses", n_valid + n_ferr, 2);

    half(1'b0);
    half(1'b1);
    for (int i = 7; i >= 4; i--) send_bit(w5a[i]);
    chk("mid busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid rst outputs",
        {data_out, data_valid, frame_err, busy, parity_err}, 0);
    line_in = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("mid rst pulses", n_valid + n_ferr, 2);

    send_frame(8'h81, -1);
    wait_idle(n);
    chk("81 data_out", data_out, 8'h81);
    chk("81 valid count", n_valid, 2);

    send_frame(8'hFF, -1);
    repeat (8) tick();
    send_frame(8'h00, -1);
    wait_idle(n);
    chk("b2b valid count", n_valid, 4);
    chk("b2b word0", words[2], 8'hFF);
    chk("b2b word1", words[3], 8'h00);
    chk("b2b frame_err", n_ferr, 1);

`ifdef MANCH_PARITY_EN
    par_force = 0;
    send_frame(8'h07, -1);
    wait_idle(n);
    chk("par0 data_out", data_out, 8'h07);
    chk("par0 valid count", n_valid, 5);
    chk("par0 perr with valid", n_perr_v, 1);
    chk("par0 perr count", n_perr, 1);
    par_force = 1;
    send_frame(8'h07, -1);
    wait_idle(n);
    chk("par1 valid count", n_valid, 6);
    chk("par1 perr count", n_perr, 1);
    par_force = -1;
`else
    chk("no parity_err", n_perr, 0);
`endif
    chk("valid/err overlap", n_both, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
